// File: rtl/mpsoc_ahb3_pkg.sv
// Shared AHB3-Lite encodings, responder FSM states and the byte-lane helper
// used by the external-port responder and its RAM.
package mpsoc_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } ahb3_state_e;

  // Little-endian lane enables; unsupported sizes enable nothing.
  function automatic logic [3:0] ahb3_byte_en(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      HSIZE_BYTE:  ahb3_byte_en = 4'b0001 << lsb;
      HSIZE_HWORD: ahb3_byte_en = lsb[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD:  ahb3_byte_en = 4'b1111;
      default:     ahb3_byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mpsoc_ahb3_ram.sv
// Word-organised scratch RAM with byte-enabled synchronous write and a
// registered read port; the read returns the pre-write contents on a collision.
module mpsoc_ahb3_ram
  import mpsoc_ahb3_pkg::*;
#(
  parameter int MEM_SIZE = 4096,
  parameter int IW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [IW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  localparam int DEPTH = 2 ** IW;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q, rdata_d;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) rdata_d = mem_q[raddr_i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mpsoc_ahb3_ext_responder.sv
// AHB3-Lite slave terminating the MPSoC external port with a local RAM.
// Optional wait states per OKAY transfer: define MPSOC_AHB3_EXT_WAITSTATES_EN.
module mpsoc_ahb3_ext_responder
  import mpsoc_ahb3_pkg::*;
#(
  parameter int PLEN        = 32,
  parameter int XLEN        = 32,
  parameter int MEM_SIZE    = 4096,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ahb3_hsel_i,
  input  logic [PLEN-1:0] ahb3_haddr_i,
  input  logic [XLEN-1:0] ahb3_hwdata_i,
  input  logic            ahb3_hwrite_i,
  input  logic [2:0]      ahb3_hsize_i,
  input  logic [2:0]      ahb3_hburst_i,
  input  logic [3:0]      ahb3_hprot_i,
  input  logic [1:0]      ahb3_htrans_i,
  input  logic            ahb3_hmastlock_i,
  output logic [XLEN-1:0] ahb3_hrdata_o,
  output logic            ahb3_hready_o,
  output logic            ahb3_hresp_o
);

  localparam int MAW = $clog2(MEM_SIZE);
  localparam int IW  = (MEM_SIZE > 4) ? MAW - 2 : 1;

  ahb3_state_e state_q, state_d;
  logic          hready_q, hready_d;
  logic          hresp_q, hresp_d;
  logic          write_q, write_d;
  logic [3:0]    be_q, be_d;
  logic [IW-1:0] widx_q, widx_d;
  logic [3:0]    fwd_be_q, fwd_be_d;
  logic [31:0]   fwd_data_q, fwd_data_d;

`ifdef MPSOC_AHB3_EXT_WAITSTATES_EN
  localparam int WCW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  logic [WCW-1:0] wcnt_q, wcnt_d;
`endif

  logic          trans_active, accept, xfer_err, good_acc;
  logic          ram_we, ram_re;
  logic [IW-1:0] rd_idx;
  logic [31:0]   ram_rdata, rdata_merged;

  always_comb begin
    case (ahb3_htrans_i)
      HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  trans_active = 1'b0;
      default:                   trans_active = 1'b0;
    endcase
  end

  assign accept   = hready_q & ahb3_hsel_i & trans_active;
  assign xfer_err = (|ahb3_haddr_i[PLEN-1:MAW])
                  | (ahb3_hsize_i > HSIZE_WORD)
                  | ((ahb3_hsize_i == HSIZE_HWORD) & ahb3_haddr_i[0])
                  | ((ahb3_hsize_i == HSIZE_WORD) & (|ahb3_haddr_i[1:0]));
  assign good_acc = accept & ~xfer_err;
  assign rd_idx   = ahb3_haddr_i[IW+1:2];
  assign ram_re   = good_acc & ~ahb3_hwrite_i;
  assign ram_we   = (state_q == ST_DATA) & write_q;

  always_comb begin
    state_d    = state_q;
    hready_d   = 1'b1;
    hresp_d    = HRESP_OKAY;
    write_d    = write_q;
    be_d       = be_q;
    widx_d     = widx_q;
    fwd_be_d   = fwd_be_q;
    fwd_data_d = fwd_data_q;
`ifdef MPSOC_AHB3_EXT_WAITSTATES_EN
    wcnt_d     = wcnt_q;
`endif

    // A read accepted while a write to the same word retires must see the new lanes.
    if (ram_re) begin
      fwd_be_d   = (ram_we && (widx_q == rd_idx)) ? be_q : 4'b0000;
      fwd_data_d = ahb3_hwdata_i[31:0];
    end

    case (state_q)
`ifdef MPSOC_AHB3_EXT_WAITSTATES_EN
      ST_WAIT: begin
        if (wcnt_q == '0) begin
          state_d = ST_DATA;
        end else begin
          hready_d = 1'b0;
          wcnt_d   = wcnt_q - 1'b1;
        end
      end
`endif
      ST_ERR1: begin
        state_d = ST_ERR2;
        hresp_d = HRESP_ERROR;
      end
      default: begin
        if (accept) begin
          if (xfer_err) begin
            state_d  = ST_ERR1;
            hready_d = 1'b0;
            hresp_d  = HRESP_ERROR;
            write_d  = 1'b0;
          end else begin
            write_d = ahb3_hwrite_i;
            be_d    = ahb3_byte_en(ahb3_hsize_i, ahb3_haddr_i[1:0]);
            widx_d  = rd_idx;
            state_d = ST_DATA;
`ifdef MPSOC_AHB3_EXT_WAITSTATES_EN
            if (WAIT_STATES != 0) begin
              state_d  = ST_WAIT;
              hready_d = 1'b0;
              wcnt_d   = WCW'(WAIT_STATES - 1);
            end
`endif
          end
        end else begin
          state_d = ST_IDLE;
          write_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hready_q   <= 1'b1;
      hresp_q    <= HRESP_OKAY;
      write_q    <= 1'b0;
      be_q       <= 4'b0000;
      widx_q     <= '0;
      fwd_be_q   <= 4'b0000;
      fwd_data_q <= '0;
`ifdef MPSOC_AHB3_EXT_WAITSTATES_EN
      wcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      hready_q   <= hready_d;
      hresp_q    <= hresp_d;
      write_q    <= write_d;
      be_q       <= be_d;
      widx_q     <= widx_d;
      fwd_be_q   <= fwd_be_d;
      fwd_data_q <= fwd_data_d;
`ifdef MPSOC_AHB3_EXT_WAITSTATES_EN
      wcnt_q     <= wcnt_d;
`endif
    end
  end

  mpsoc_ahb3_ram #(
    .MEM_SIZE (MEM_SIZE),
    .IW       (IW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we),
    .be_i    (be_q),
    .waddr_i (widx_q),
    .wdata_i (ahb3_hwdata_i[31:0]),
    .re_i    (ram_re),
    .raddr_i (rd_idx),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    rdata_merged = ram_rdata;
    for (int b = 0; b < 4; b++) begin
      if (fwd_be_q[b]) rdata_merged[8*b +: 8] = fwd_data_q[8*b +: 8];
    end
  end

  assign ahb3_hrdata_o = rdata_merged;
  assign ahb3_hready_o = hready_q;
  assign ahb3_hresp_o  = hresp_q;

  logic unused_ok;
`ifdef MPSOC_AHB3_EXT_WAITSTATES_EN
  assign unused_ok = ^{ahb3_hburst_i, ahb3_hprot_i, ahb3_hmastlock_i};
`else
  assign unused_ok = ^{ahb3_hburst_i, ahb3_hprot_i, ahb3_hmastlock_i, 1'(WAIT_STATES)};
`endif

endmodule

// File: tb/tb_mpsoc_ahb3_ext_responder.sv
// Self-checking bench for mpsoc_ahb3_ext_responder: vector table plus
// scoreboard, with reset and random back-to-back sequences.
module tb_mpsoc_ahb3_ext_responder;
  import mpsoc_ahb3_pkg::*;

`ifdef MPSOC_AHB3_EXT_WAITSTATES_EN
  localparam int WS = 2;
`else
  localparam int WS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsel = 1'b0, hwrite = 1'b0, hmastlock = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0, hrdata;
  logic [2:0]  hsize = '0, hburst = '0;
  logic [3:0]  hprot = '0;
  logic [1:0]  htrans = '0;
  logic        hready, hresp;

  always #5 clk = ~clk;

  mpsoc_ahb3_ext_responder dut (
    .clk              (clk),
    .rst              (rst),
    .ahb3_hsel_i      (hsel),
    .ahb3_haddr_i     (haddr),
    .ahb3_hwdata_i    (hwdata),
    .ahb3_hwrite_i    (hwrite),
    .ahb3_hsize_i     (hsize),
    .ahb3_hburst_i    (hburst),
    .ahb3_hprot_i     (hprot),
    .ahb3_htrans_i    (htrans),
    .ahb3_hmastlock_i (hmastlock),
    .ahb3_hrdata_o    (hrdata),
    .ahb3_hready_o    (hready),
    .ahb3_hresp_o     (hresp)
  );

  typedef struct {
    bit          wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    bit          use_model;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    vec_t v;
    int   waits;
  } sb_t;

  vec_t        issueq[$];
  sb_t         sbq[$];
  logic [31:0] mdl [1024];
  logic [31:0] last_rd = '0;
  int          total = 0;
  int          bad = 0;

  function automatic vec_t mk(bit wr, logic [2:0] size, logic [31:0] addr,
                              logic [31:0] wdata, bit err, logic [31:0] rdata);
    vec_t v;
    v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata;
    v.err = err; v.use_model = 1'b0; v.rdata = rdata;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    hsel   = 1'b1;
    haddr  = v.addr;
    hwrite = v.wr;
    hsize  = v.size;
    htrans = HTRANS_NONSEQ;
    hprot  = 4'b0011;
  endtask

  task automatic driveIdle();
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    haddr  = '0;
    hwrite = 1'b0;
  endtask

  task automatic mdlWrite(input vec_t v);
    logic [3:0] be;
    case (v.size)
      3'd0:    be = 4'b0001 << v.addr[1:0];
      3'd1:    be = 4'b0011 << v.addr[1:0];
      default: be = 4'b1111;
    endcase
    for (int b = 0; b < 4; b++)
      if (be[b]) mdl[v.addr[11:2]][8*b +: 8] = v.wdata[8*b +: 8];
  endtask

  // Runs everything in issueq back to back; called and returns at a negedge.
  task automatic runBus();
    int waits = 0;
    int cyc = 0;
    while ((issueq.size() > 0 || sbq.size() > 0) && cyc < 2000) begin
      cyc++;
      hwdata = (sbq.size() > 0) ? sbq[0].v.wdata : 32'h0;
      if (sbq.size() > 0) begin
        if (!hready) begin
          waits++;
          checkOutput("stall_resp", 32'(hresp), 32'(sbq[0].v.err));
        end else begin
          checkOutput("resp", 32'(hresp), 32'(sbq[0].v.err));
          checkOutput("wait_cycles", 32'(waits), 32'(sbq[0].waits));
          if (!sbq[0].v.wr && !sbq[0].v.err) checkOutput("rdata", hrdata, sbq[0].v.rdata);
          if (sbq[0].v.wr && !sbq[0].v.err) mdlWrite(sbq[0].v);
          void'(sbq.pop_front());
          waits = 0;
        end
      end else begin
        checkOutput("idle_ready", 32'(hready), 32'd1);
        checkOutput("idle_resp", 32'(hresp), 32'd0);
      end
      checkOutput("rdata_hold", hrdata, last_rd);
      if (hready) begin
        if (issueq.size() > 0) begin
          vec_t v;
          sb_t  s;
          v = issueq.pop_front();
          if (v.use_model && !v.wr) v.rdata = mdl[v.addr[11:2]];
          applyStimulus(v);
          s.v = v;
          s.waits = v.err ? 1 : WS;
          sbq.push_back(s);
          if (!v.wr && !v.err) last_rd = v.rdata;
        end else begin
          driveIdle();
        end
      end
      @(negedge clk);
    end
    if (cyc >= 2000) begin
      bad++;
      total++;
      $display("[TB] FAIL bus_timeout: got %0d pending expected 0", sbq.size());
      issueq.delete();
      sbq.delete();
    end
    driveIdle();
    hwdata = '0;
  endtask

  vec_t tbl[20];

  initial begin
    tbl[0]  = mk(1, HSIZE_WORD,  32'h010,  32'hDEADBEEF, 0, '0);
    tbl[1]  = mk(0, HSIZE_WORD,  32'h010,  32'h0,        0, 32'hDEADBEEF);
    tbl[2]  = mk(1, HSIZE_WORD,  32'h020,  32'h00000000, 0, '0);
    tbl[3]  = mk(1, HSIZE_BYTE,  32'h021,  32'h0000AA00, 0, '0);
    tbl[4]  = mk(1, HSIZE_HWORD, 32'h022,  32'h12340000, 0, '0);
    tbl[5]  = mk(0, HSIZE_WORD,  32'h020,  32'h0,        0, 32'h1234AA00);
    tbl[6]  = mk(1, HSIZE_WORD,  32'h000,  32'hCAFEF00D, 0, '0);
    tbl[7]  = mk(0, HSIZE_WORD,  32'h1000, 32'h0,        1, '0);
    tbl[8]  = mk(0, HSIZE_HWORD, 32'h003,  32'h0,        1, '0);
    tbl[9]  = mk(0, HSIZE_WORD,  32'h000,  32'h0,        0, 32'hCAFEF00D);
    tbl[10] = mk(1, HSIZE_WORD,  32'h004,  32'h11223344, 0, '0);
    tbl[11] = mk(1, HSIZE_BYTE,  32'h007,  32'h5A000000, 0, '0);
    tbl[12] = mk(0, HSIZE_HWORD, 32'h006,  32'h0,        0, 32'h5A223344);
    tbl[13] = mk(1, HSIZE_WORD,  32'hFFC,  32'h0BADCAFE, 0, '0);
    tbl[14] = mk(0, HSIZE_BYTE,  32'hFFF,  32'h0,        0, 32'h0BADCAFE);
    tbl[15] = mk(1, HSIZE_WORD,  32'h1010, 32'h77777777, 1, '0);
    tbl[16] = mk(1, 3'd3,        32'h010,  32'hFFFFFFFF, 1, '0);
    tbl[17] = mk(1, HSIZE_HWORD, 32'h011,  32'h0000FFFF, 1, '0);
    tbl[18] = mk(1, HSIZE_WORD,  32'h012,  32'h55555555, 1, '0);
    tbl[19] = mk(0, HSIZE_WORD,  32'h010,  32'h0,        0, 32'hDEADBEEF);

    // Reset, then five idle cycles at reset values.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("reset_ready", 32'(hready), 32'd1);
      checkOutput("reset_resp", 32'(hresp), 32'd0);
      checkOutput("reset_rdata", hrdata, 32'h0);
    end

    $display("[TB] vector table");
    for (int i = 0; i < 20; i++) issueq.push_back(tbl[i]);
    runBus();

    // Reset lands while a write to 0x4 sits in its data phase.
    $display("[TB] reset during write");
    applyStimulus(mk(1, HSIZE_WORD, 32'h004, 32'h0, 0, '0));
    @(negedge clk);
    driveIdle();
    hwdata = 32'h00000055;
    checkOutput("midwrite_ready", 32'(hready), (WS == 0) ? 32'd1 : 32'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_ready", 32'(hready), 32'd1);
    checkOutput("async_rst_resp", 32'(hresp), 32'd0);
    checkOutput("async_rst_rdata", hrdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    hwdata = '0;
    last_rd = '0;
    issueq.push_back(mk(0, HSIZE_WORD, 32'h004, 32'h0, 0, 32'h5A223344));
    runBus();

    $display("[TB] random back-to-back traffic");
    for (int w = 0; w < 8; w++)
      issueq.push_back(mk(1, HSIZE_WORD, 32'h100 + 32'(w * 4), $urandom, 0, '0));
    for (int i = 0; i < 32; i++) begin
      vec_t v;
      logic [2:0]  sz;
      logic [31:0] off;
      sz = 3'($urandom_range(0, 2));
      off = (sz == 3'd0) ? 32'($urandom_range(0, 3)) :
            (sz == 3'd1) ? 32'(2 * $urandom_range(0, 1)) : 32'd0;
      v = mk(1'($urandom_range(0, 1)), sz, 32'h100 + 32'(4 * $urandom_range(0, 7)) + off,
             $urandom, 0, '0);
      v.use_model = 1'b1;
      issueq.push_back(v);
    end
    runBus();

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
